// File: rtl/bounce_gen.sv
// Switch-bounce emulator: each change of the clean input level becomes a burst of
// 2*BOUNCES+1 toggles on out, then a 2^N-cycle settle period closed by a one-cycle tick.
// Define BOUNCE_GEN_FIXED_INTERVAL_EN for a fixed 2^(N-1)-cycle toggle spacing instead of LFSR spacing.
module bounce_gen #(
    parameter int unsigned N       = 2,
    parameter int unsigned BOUNCES = 3,
    parameter logic [7:0]  SEED    = 8'hA5
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out,
    output logic busy,
    output logic tick
);

    localparam int unsigned REM_W       = (BOUNCES == 0) ? 1 : $clog2(2 * BOUNCES + 1);
    localparam logic [REM_W-1:0] REM_INIT = REM_W'(2 * BOUNCES);
    localparam logic [N-1:0] SETTLE_LOAD = '1;
    localparam logic [7:0]  SEED_EFF    = (SEED == 8'h00) ? 8'h01 : SEED;

    typedef enum logic [1:0] {
        IDLE,
        BOUNCE,
        SETTLE
    } state_t;

    state_t           state, state_n;
    logic [N-1:0]     cnt, cnt_n;
    logic [REM_W-1:0] rem, rem_n;
    logic             target, target_n;
    logic             out_n;
    logic             busy_n;
    logic             tick_n;
    logic [7:0]       lfsr;
    logic             lfsr_fb;
    logic [N-1:0]     reload;

    // x^8+x^6+x^5+x^4+1; a non-zero seed keeps it out of the all-zero lock-up state
    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

`ifdef BOUNCE_GEN_FIXED_INTERVAL_EN
    localparam logic [N-1:0] FIXED_LOAD = N'((1 << (N - 1)) - 1);
    assign reload = FIXED_LOAD;
`else
    assign reload = lfsr[N-1:0];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            rem    <= '0;
            target <= 1'b0;
            out    <= 1'b0;
            busy   <= 1'b0;
            tick   <= 1'b0;
            lfsr   <= SEED_EFF;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            rem    <= rem_n;
            target <= target_n;
            out    <= out_n;
            busy   <= busy_n;
            tick   <= tick_n;
            lfsr   <= {lfsr[6:0], lfsr_fb};
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        rem_n    = rem;
        target_n = target;
        out_n    = out;
        tick_n   = 1'b0;

        case (state)
            IDLE: begin
                if (in != out) begin
                    target_n = in;
                    out_n    = ~out;
                    rem_n    = REM_INIT;
                    if (BOUNCES == 0) begin
                        cnt_n   = SETTLE_LOAD;
                        state_n = SETTLE;
                    end else begin
                        cnt_n   = reload;
                        state_n = BOUNCE;
                    end
                end
            end
            BOUNCE: begin
                if (cnt != '0) begin
                    cnt_n = cnt - N'(1);
                end else begin
                    rem_n = rem - REM_W'(1);
                    if (rem == REM_W'(1)) begin
                        // final toggle of an odd-length burst lands on the latched level
                        out_n   = target;
                        cnt_n   = SETTLE_LOAD;
                        state_n = SETTLE;
                    end else begin
                        out_n = ~out;
                        cnt_n = reload;
                    end
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                    tick_n  = 1'b1;
                end else begin
                    cnt_n = cnt - N'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule
